// File: rtl/bus_arbiter_card_pkg.sv
// Shared types and constants for the backplane bus arbiter.
// Master index assignments name the cards that normally sit on the backplane.
package bus_arbiter_card_pkg;

    localparam int ARB_NREQ      = 4;
    localparam int ARB_M_CONTROL = 0;
    localparam int ARB_M_LOADER  = 1;
    localparam int ARB_M_DEBUG   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_e;

    // Width of an index into n masters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_card_if.sv
// Request/grant bundle between the backplane masters and the bus arbiter.
interface bus_arbiter_card_if #(
    parameter int NREQ = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] lock;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            revoke_evt;

    modport master (
        output req, lock,
        input  grant, grant_id, busy, revoke_evt
    );

    modport slave (
        input  req, lock,
        output grant, grant_id, busy, revoke_evt
    );

endinterface

// File: rtl/bus_arbiter_card_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping around.
module bus_arbiter_card_rr_pick
    import bus_arbiter_card_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IDW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            found,
    output logic [IDW-1:0]  index
);

    // Scan the wrapped region first, then the region at/after ptr so that it overrides.
    always_comb begin
        found = 1'b0;
        index = {IDW{1'b0}};
        for (int j = NREQ - 1; j >= 0; j--) begin
            found = found | (req[j] & (j < int'(ptr)));
            index = (req[j] && (j < int'(ptr))) ? IDW'(j) : index;
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            found = found | (req[j] & (j >= int'(ptr)));
            index = (req[j] && (j >= int'(ptr))) ? IDW'(j) : index;
        end
    end

endmodule

// File: rtl/bus_arbiter_card.sv
// Backplane bus arbiter: round-robin grant, turnaround gap between owners,
// and optional revocation of an unlocked holder that overstays MAX_HOLD cycles.
module bus_arbiter_card
    import bus_arbiter_card_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic clk,
    input  logic rst_n,
    bus_arbiter_card_if.slave bus
);

    localparam int IDW = idx_width(NREQ);
    localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW  = 4;
    localparam logic [HW-1:0]  HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [TW-1:0]  TURN_LAST = TW'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    arb_state_e      state_q,    state_d;
    logic [IDW-1:0]  ptr_q,      ptr_d;
    logic [HW-1:0]   hold_q,     hold_d;
    logic [TW-1:0]   turn_q,     turn_d;
    logic [NREQ-1:0] grant_q,    grant_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            busy_q,     busy_d;
    logic            revoke_q,   revoke_d;

    logic            found_s;
    logic [IDW-1:0]  pick_s;
    logic            holder_req_s;
    logic            holder_lock_s;
    logic            other_req_s;
    logic            revoke_s;

    bus_arbiter_card_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .found (found_s),
        .index (pick_s)
    );

    // Holder status, masked through the one-hot grant.
    always_comb begin
        holder_req_s  = |(bus.req  & grant_q);
        holder_lock_s = |(bus.lock & grant_q);
        other_req_s   = |(bus.req  & ~grant_q);
        revoke_s      = (MAX_HOLD > 0) && (hold_q == HOLD_SAT) && !holder_lock_s && other_req_s;
    end

    // Next-state logic for the arbitration FSM and its registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        turn_d     = turn_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        revoke_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d    = ST_GRANT;
                    grant_d    = ONE_HOT0 << pick_s;
                    grant_id_d = pick_s;
                    hold_d     = {HW{1'b0}};
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!holder_req_s || revoke_s) begin
                    // A revoke is an end of grant while the holder still requests.
                    grant_d  = {NREQ{1'b0}};
                    revoke_d = holder_req_s;
                    ptr_d    = (grant_id_q == ID_LAST) ? {IDW{1'b0}} : grant_id_q + IDW'(1);
                    turn_d   = {TW{1'b0}};
                    state_d  = (TURN > 0) ? ST_TURN : ST_IDLE;
                end else begin
                    hold_d   = (hold_q == HOLD_SAT) ? hold_q : hold_q + HW'(1);
                end
            end
            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d  = turn_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = {NREQ{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= {IDW{1'b0}};
            hold_q     <= {HW{1'b0}};
            turn_q     <= {TW{1'b0}};
            grant_q    <= {NREQ{1'b0}};
            grant_id_q <= {IDW{1'b0}};
            busy_q     <= 1'b0;
            revoke_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            revoke_q   <= revoke_d;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = busy_q;
    assign bus.revoke_evt = revoke_q;

endmodule

// File: doc/bus_arbiter_card.md
Name: bus_arbiter_card

Overview:
- Arbitrates ownership of the shared backplane bus (data, addr, ctrl) between multiple bus-master cards, e.g. the control card sequencer, a program loader card and a debug/monitor card.
- Grants the bus to exactly one requester at a time, using round-robin fairness.
- Enforces a bus-idle turnaround gap between owners so tri-state drivers never contend.
- Optionally revokes the bus from a holder that keeps it too long.

Parameters:
- NREQ, 4, number of requesting masters (2..8).
- TURN, 1, extra idle cycles inserted after a release or revoke (0..15).
- MAX_HOLD, 64, grant cycles before an unlocked holder may be revoked. 0 disables revocation.

Ports:
- clk  in  1  backplane clock, from the clock card.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-master request. Held high for the whole time the master wants the bus.
- lock  in  NREQ  per-master lock. While the holder's bit is high, the holder is never revoked.
- grant  out  NREQ  one-hot grant. The master may drive the bus only while its bit is high.
- grant_id  out  $clog2(NREQ)  index of the current or most recent owner.
- busy  out  1  high whenever the state is not IDLE.
- revoke_evt  out  1  one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- All state and outputs are registered and update on the rising edge of clk only.
- Reset (rst_n low at an edge):
  - grant=0, grant_id=0, busy=0, revoke_evt=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0, turnaround counter=0.
  - Reset applied mid-grant drops the grant at that same edge. There is no turnaround on reset exit.
- States: IDLE, GRANT, TURNAROUND.
- IDLE:
  - If any req bit is high, pick the first set bit scanning from ptr upward, wrapping modulo NREQ.
  - Next edge: grant[i]=1, grant_id=i, state=GRANT, hold counter=0.
  - Latency from req sampled high to grant high is 1 cycle.
- GRANT, normal operation:
  - The hold counter increments each cycle and saturates at MAX_HOLD.
  - Requests from other masters do not affect the current grant.
- GRANT, release:
  - Triggered when req[i] is sampled low.
  - Next edge: grant=0, ptr=(i+1) mod NREQ.
  - State becomes TURNAROUND if TURN>0, otherwise IDLE.
- GRANT, revoke:
  - Condition: MAX_HOLD>0, hold counter==MAX_HOLD, lock[i]=0, and any other req bit high.
  - Actions: grant=0, revoke_evt=1 for that one cycle, ptr=(i+1) mod NREQ, state as for release.
  - The revoked master keeps its req high and competes again under round-robin.
- GRANT, lock interaction:
  - If lock[i] is high, the holder is never revoked.
  - If lock[i] drops with the counter already saturated and another requester pending, revoke on the next evaluating edge.
- TURNAROUND: counts TURN cycles with grant=0, then goes to IDLE.
- Idle gap between consecutive owners is TURN+1 cycles: TURN turnaround cycles plus the IDLE arbitration cycle.
- Single requester:
  - It is never revoked, since revocation requires another pending request.
  - If it releases and re-requests, it is re-granted after the normal gap.
- Request pulses: req is sampled only in IDLE. A request that rises and falls entirely within a non-IDLE window is lost.
- Unused upper grant_id codes (NREQ not a power of two) never occur.
- Invariant: grant is always zero or one-hot.

Decomposition:
- config.v defines:
  - `ARB_NREQ, the default master count.
  - `ARB_IDLE, `ARB_GRANT, `ARB_TURN, the 2-bit state encodings.
  - `ARB_M_CONTROL=0, `ARB_M_LOADER=1, `ARB_M_DEBUG=2, the master index assignments.
- Sub-module rr_pick, purely combinational:
  - Inputs: req, ptr.
  - Outputs: found and index, for the first set bit at or after ptr, with wrap.
  - Instantiated once in bus_arbiter_card.

Test Plan:
- Reset then req=4'b0101 at cycle 2: grant=0001 at cycle 3. Drop req[0] at cycle 6: grant=0 for 2 cycles (TURN=1), then grant=0100, grant_id=2.
- Round-robin fairness: all four req held high and each holder drops its req after 3 cycles. Required grant order: 0,1,2,3,0. No grant overlap, gap always 2 cycles.
- Timeout: MAX_HOLD=8, master 1 holds req with lock=0 and master 3 requests. After 8 grant cycles, revoke_evt pulses for 1 cycle, then grant=1000. Repeat with lock[1]=1: no revoke over 100 cycles.
- Single requester: req=0010 held for 200 cycles with MAX_HOLD=8. Grant stays 0010 and revoke_evt never fires.
- Reset mid-grant: rst_n low for 1 cycle while grant=0100. At that edge grant=0, busy=0, ptr=0. With req=1111 afterwards, the first grant is 0001.
- TURN=0 and NREQ=3: release of master 2 is followed by a 1-cycle gap, then grant to master 0 (wrap). grant_id never reaches 3.
